// File: rtl/note_spawner_if.sv
// note_spawner_if: RNG request/sample link for the note spawner.
// rng_enable requests a nibble; rng_rnd is valid while it is high.
interface note_spawner_if;
  logic       rng_enable;
  logic [3:0] rng_rnd;

  modport master (
    output rng_enable,
    input  rng_rnd
  );

  modport slave (
    input  rng_enable,
    output rng_rnd
  );
endinterface

// File: rtl/note_spawner.sv
// note_spawner: beat-driven 4-lane note highway with key judging.
// Ports: clk, rst (async, active-low), start, pause, keys[3:0],
//   rng (master: rng_enable out, rng_rnd in), highway[4*ROWS-1:0],
//   bottom_row[3:0], hit, miss, streak[7:0], busy.
module note_spawner #(
  parameter int BEAT_DIV = 12500000,
  parameter int ROWS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [3:0]        keys,
  note_spawner_if.master    rng,
  output logic [4*ROWS-1:0] highway,
  output logic [3:0]        bottom_row,
  output logic              hit,
  output logic              miss,
  output logic [7:0]        streak,
  output logic              busy
);

  localparam int CW =
    (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN_WAIT,
    REQ,
    CAPT,
    JUDGE,
    SHIFT
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    key_acc;
  logic [3:0]    keys_q;
  logic [3:0]    nib;
  logic [2:0]    pc;
  logic [3:0]    mask;
  logic          match;
  logic          j_hit;
  logic          j_miss;

  assign rng.rng_enable = (st == REQ) || (st == CAPT);
  assign busy       = (st != IDLE);
  assign bottom_row = highway[4*ROWS-1 -: 4];

  // Chords of three or four lanes become rests.
  assign pc = {2'b0, nib[0]} + {2'b0, nib[1]}
            + {2'b0, nib[2]} + {2'b0, nib[3]};
  assign mask = (pc > 3'd2) ? 4'h0 : nib;

  // An empty row with no presses is neither hit nor miss.
  assign match  = (key_acc == bottom_row);
  assign j_hit  = match && (bottom_row != 4'h0);
  assign j_miss = !match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE:     if (start) nxt = RUN_WAIT;
      RUN_WAIT: if (!pause && cnt == LAST) nxt = REQ;
      REQ:      nxt = CAPT;
      CAPT:     nxt = JUDGE;
      JUDGE:    nxt = SHIFT;
      SHIFT:    nxt = RUN_WAIT;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      highway <= '0;
      streak  <= '0;
      hit     <= 1'b0;
      miss    <= 1'b0;
      cnt     <= '0;
      key_acc <= '0;
      keys_q  <= '0;
      nib     <= '0;
    end else begin
      keys_q <= keys;
      hit    <= 1'b0;
      miss   <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            highway <= '0;
            streak  <= '0;
            key_acc <= '0;
            cnt     <= '0;
          end
        end
        RUN_WAIT: begin
          if (!pause) begin
            key_acc <= key_acc | (keys & ~keys_q);
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
          end
        end
        CAPT: nib <= rng.rng_rnd;
        JUDGE: begin
          hit     <= j_hit;
          miss    <= j_miss;
          key_acc <= '0;
          unique case (1'b1)
            j_hit:
              if (streak != 8'hFF) streak <= streak + 8'd1;
            j_miss:  streak <= '0;
            default: ;
          endcase
        end
        SHIFT:
          highway <= {highway[4*ROWS-5:0], mask};
        default: ;
      endcase
    end
  end

endmodule

// File: doc/note_spawner.md
Name: note_spawner

Overview:
- Consumes the 4-bit output of the game's LFSR random source and builds the falling-note highway for a 4-lane rhythm game on the DE2 board.
- On every beat it performs these steps in order:
  - Requests a fresh nibble over the RNG enable/sample interface.
  - Filters the nibble into a lane mask.
  - Judges the player's key presses against the bottom row.
  - Scrolls the highway down one row.
- Sits between the RNG and the VGA/score logic.

Parameters:
- BEAT_DIV, 12500000: RUN_WAIT length in clk cycles (50 MHz / 4).
- ROWS, 8: highway depth in rows; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a song from IDLE.
- pause  in  1  level; freezes beat progress while high.
- rng_rnd  in  4  nibble from the RNG; valid while rng_enable is high.
- rng_enable  out  1  request/hold strobe to the RNG.
- keys  in  4  lane buttons; active-high, already debounced and synchronised.
- highway  out  4*ROWS  row r occupies bits [4r+3:4r]; row 0 is the top, row ROWS-1 is the bottom.
- bottom_row  out  4  equals highway row ROWS-1.
- hit  out  1  one-cycle pulse on a correct judgement.
- miss  out  1  one-cycle pulse on a wrong judgement.
- streak  out  8  consecutive hits, saturating at 255.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous) sets all of the following, and holds them until rst returns to 1:
  - state = IDLE; highway = 0; streak = 0.
  - hit = miss = rng_enable = 0.
  - beat counter = 0; key_acc = 0; keys_q = 0.
- States: IDLE, RUN_WAIT, REQ, CAPT, JUDGE, SHIFT.
- IDLE:
  - On start=1: clear highway, streak, key_acc and beat counter; next state RUN_WAIT.
  - Otherwise stay in IDLE.
- RUN_WAIT:
  - When pause=0, the counter increments each cycle.
  - When counter == BEAT_DIV-1: clear the counter and go to REQ.
  - When pause=1, the counter holds and key edges are discarded.
- Beat period with pause=0 is exactly BEAT_DIV+4 cycles.
- REQ and CAPT:
  - rng_enable = 1 in both states, 0 in all others (exactly 2 cycles per beat).
  - At the clock edge leaving CAPT, rng_rnd is registered into nib.
- Lane filter, evaluated in JUDGE from nib:
  - If popcount(nib) > 2, mask = 4'b0000 (rest). This covers 7, B, D, E and F.
  - Otherwise mask = nib; nib = 0 is also a rest.
- Key capture:
  - keys_q registers keys every cycle.
  - A rising edge on lane i (keys[i] & ~keys_q[i]) during RUN_WAIT with pause=0 sets key_acc[i].
  - Edges in REQ, CAPT, JUDGE or SHIFT are dropped.
  - Held keys produce no further edges.
- JUDGE (one cycle), with B = bottom_row:
  - B != 0 and key_acc == B: hit pulse; streak += 1, saturating at 255.
  - B != 0 and key_acc != B (missing or extra lane): miss pulse; streak = 0.
  - B == 0 and key_acc != 0 (stray press): miss pulse; streak = 0.
  - B == 0 and key_acc == 0: no pulse; streak unchanged.
  - key_acc clears at the end of JUDGE.
  - hit and miss are never high together; each is high for exactly the cycle after JUDGE.
- SHIFT (one cycle):
  - Row r+1 takes row r for r = 0..ROWS-2; row 0 takes mask.
  - The old bottom row is discarded.
  - Next state RUN_WAIT.
- Latency: a spawned note reaches bottom_row ROWS-1 beats after its SHIFT, and is judged at the following JUDGE.
- Edge cases:
  - start outside IDLE: ignored.
  - pause asserted outside RUN_WAIT: the current beat sequence (REQ through SHIFT) completes, then the FSM holds in RUN_WAIT.
  - Reset mid-beat: immediate return to the reset values; rng_enable drops asynchronously.
- No song end: the FSM runs until reset.

Test Plan:
1. Reset and idle: rst=0 mid-CAPT -> rng_enable, highway, streak, hit and miss all 0 immediately; busy=0 after release; no rng_enable activity without start.
2. Handshake timing (BEAT_DIV=4, ROWS=4, rng_rnd=4'h3): start -> rng_enable high for exactly 2 cycles, every 8 cycles; row 0 = 3 after the first SHIFT; bottom_row = 3 after the 4th SHIFT.
3. Filter: rng_rnd sequence F, 7, 0, 5, 8 -> rows spawned 0, 0, 0, 5, 8.
4. Judging:
   - Bottom row 5, key edges on lanes 0 and 2 -> hit; streak 0→1.
   - Next bottom row 8, keys=4'h9 -> miss; streak=0.
   - Bottom row 0 with no keys -> no pulse.
   - Bottom row 0 with a lane-1 press -> miss.
5. Saturation and held keys:
   - 256 consecutive hits -> streak stays 255.
   - A key held across two beats counts only in the first beat's window.
6. Pause: pause=1 for 20 cycles in RUN_WAIT -> counter frozen, presses ignored, no rng_enable; beat resumes at the same count after pause=0.
